// File: rtl/pipeline_stage_regs_pkg.sv
// Shared widths, control-bit maps and payload types for the MIPS inter-stage registers.
package pipeline_stage_regs_pkg;

    localparam int unsigned DW        = 32;
    localparam int unsigned RW        = 5;
    localparam int unsigned PAGE_W    = 4;
    localparam int unsigned ID_CTRL_W = 9;
    localparam int unsigned EX_CTRL_W = 4;

    // ID/EX control word bit positions
    localparam int unsigned CTRL_MEM_WRITE  = 8;
    localparam int unsigned CTRL_MEM_READ   = 7;
    localparam int unsigned CTRL_REG_WRITE  = 6;
    localparam int unsigned CTRL_REG_DST    = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_ALU_OP_HI  = 2;
    localparam int unsigned CTRL_ALU_OP_LO  = 0;

    // EX/MEM control word bit positions
    localparam int unsigned EXC_MEM_WRITE  = 3;
    localparam int unsigned EXC_MEM_READ   = 2;
    localparam int unsigned EXC_REG_WRITE  = 1;
    localparam int unsigned EXC_MEM_TO_REG = 0;

    localparam logic [DW-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_op;
    } id_ctrl_t;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic reg_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    // Subset of the decode control word that travels past execute.
    function automatic ex_ctrl_t to_ex_ctrl(input id_ctrl_t c);
        ex_ctrl_t e;
        e.mem_write  = c.mem_write;
        e.mem_read   = c.mem_read;
        e.reg_write  = c.reg_write;
        e.mem_to_reg = c.mem_to_reg;
        return e;
    endfunction

endpackage

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// Generic pipeline register: sync active-low reset, then clear, then enable, else hold.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Clear beats enable so a flush lands even while the stage is stalled.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX and EX/MEM registers of the 5-stage MIPS pipeline, one pipe_reg per stage.
module pipeline_stage_regs
    import pipeline_stage_regs_pkg::*;
#(
    parameter int unsigned DW = pipeline_stage_regs_pkg::DW,
    parameter int unsigned RW = pipeline_stage_regs_pkg::RW
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 if_id_flush,
    input  logic                 if_id_write,
    input  logic [DW-1:0]        if_instr,
    input  logic [DW-1:0]        if_pc_plus4,
    input  logic [PAGE_W-1:0]    if_pc_page,
    output logic [DW-1:0]        if_id_instr,
    output logic [DW-1:0]        if_id_pc_plus4,
    output logic [PAGE_W-1:0]    if_id_pc_page,

    input  logic [ID_CTRL_W-1:0] id_ctrl,
    input  logic [DW-1:0]        id_rd1,
    input  logic [DW-1:0]        id_rd2,
    input  logic [DW-1:0]        id_imm,
    input  logic [3*RW-1:0]      id_regs,
    output logic [ID_CTRL_W-1:0] id_ex_ctrl,
    output logic [DW-1:0]        id_ex_rd1,
    output logic [DW-1:0]        id_ex_rd2,
    output logic [DW-1:0]        id_ex_imm,
    output logic [3*RW-1:0]      id_ex_regs,

    input  logic [EX_CTRL_W-1:0] ex_ctrl,
    input  logic [RW-1:0]        ex_dst,
    input  logic                 ex_zero,
    input  logic [DW-1:0]        ex_alu_result,
    input  logic [DW-1:0]        ex_wdata,
    output logic [EX_CTRL_W-1:0] ex_mem_ctrl,
    output logic [RW-1:0]        ex_mem_dst,
    output logic                 ex_mem_zero,
    output logic [DW-1:0]        ex_mem_alu_result,
    output logic [DW-1:0]        ex_mem_wdata
);

    localparam int unsigned IF_ID_W  = 2 * DW + PAGE_W;
    localparam int unsigned ID_EX_W  = ID_CTRL_W + 3 * DW + 3 * RW;
    localparam int unsigned EX_MEM_W = EX_CTRL_W + RW + 1 + 2 * DW;

    logic [IF_ID_W-1:0]  if_id_d;
    logic [IF_ID_W-1:0]  if_id_q;
    logic [ID_EX_W-1:0]  id_ex_d;
    logic [ID_EX_W-1:0]  id_ex_q;
    logic [EX_MEM_W-1:0] ex_mem_d;
    logic [EX_MEM_W-1:0] ex_mem_q;

    // Field order inside each stage word is fixed here and unpacked identically below.
    always_comb begin
        if_id_d  = {if_instr, if_pc_plus4, if_pc_page};
        id_ex_d  = {id_ctrl, id_rd1, id_rd2, id_imm, id_regs};
        ex_mem_d = {ex_ctrl, ex_dst, ex_zero, ex_alu_result, ex_wdata};
    end

    pipe_reg #(.W(IF_ID_W)) u_if_id (
        .clk (clk),
        .rst (rst),
        .en  (if_id_write),
        .clr (if_id_flush),
        .d   (if_id_d),
        .q   (if_id_q)
    );

    // Bubbles reach ID/EX as zeroed id_ctrl, so these stages never stall or flush.
    pipe_reg #(.W(ID_EX_W)) u_id_ex (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (id_ex_d),
        .q   (id_ex_q)
    );

    pipe_reg #(.W(EX_MEM_W)) u_ex_mem (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .clr (1'b0),
        .d   (ex_mem_d),
        .q   (ex_mem_q)
    );

    assign {if_id_instr, if_id_pc_plus4, if_id_pc_page} = if_id_q;
    assign {id_ex_ctrl, id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_regs} = id_ex_q;
    assign {ex_mem_ctrl, ex_mem_dst, ex_mem_zero, ex_mem_alu_result, ex_mem_wdata} = ex_mem_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed plus random bench for pipeline_stage_regs with an expected-output scoreboard queue.
module tb_pipeline_stage_regs;
    import pipeline_stage_regs_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_id_flush, if_id_write;
    logic [DW-1:0]        if_instr, if_pc_plus4;
    logic [PAGE_W-1:0]    if_pc_page;
    logic [DW-1:0]        if_id_instr, if_id_pc_plus4;
    logic [PAGE_W-1:0]    if_id_pc_page;
    logic [ID_CTRL_W-1:0] id_ctrl, id_ex_ctrl;
    logic [DW-1:0]        id_rd1, id_rd2, id_imm, id_ex_rd1, id_ex_rd2, id_ex_imm;
    logic [3*RW-1:0]      id_regs, id_ex_regs;
    logic [EX_CTRL_W-1:0] ex_ctrl, ex_mem_ctrl;
    logic [RW-1:0]        ex_dst, ex_mem_dst;
    logic                 ex_zero, ex_mem_zero;
    logic [DW-1:0]        ex_alu_result, ex_wdata, ex_mem_alu_result, ex_mem_wdata;

    typedef struct {
        logic [DW-1:0]        instr, pc4;
        logic [PAGE_W-1:0]    page;
        logic [ID_CTRL_W-1:0] idc;
        logic [DW-1:0]        rd1, rd2, imm;
        logic [3*RW-1:0]      regs;
        logic [EX_CTRL_W-1:0] exc;
        logic [RW-1:0]        dst;
        logic                 zero;
        logic [DW-1:0]        alu, wdata;
    } exp_t;

    exp_t m;          // model state: what each register should hold
    exp_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    pipeline_stage_regs dut (
        .clk(clk), .rst(rst),
        .if_id_flush(if_id_flush), .if_id_write(if_id_write),
        .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .if_pc_page(if_pc_page),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_pc_page(if_id_pc_page),
        .id_ctrl(id_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_regs(id_regs),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2),
        .id_ex_imm(id_ex_imm), .id_ex_regs(id_ex_regs),
        .ex_ctrl(ex_ctrl), .ex_dst(ex_dst), .ex_zero(ex_zero),
        .ex_alu_result(ex_alu_result), .ex_wdata(ex_wdata),
        .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_dst(ex_mem_dst), .ex_mem_zero(ex_mem_zero),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_wdata(ex_mem_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ":if_id_instr"},    if_id_instr,             e.instr);
        check({tag, ":if_id_pc_plus4"}, if_id_pc_plus4,          e.pc4);
        check({tag, ":if_id_pc_page"},  DW'(if_id_pc_page),      DW'(e.page));
        check({tag, ":id_ex_ctrl"},     DW'(id_ex_ctrl),         DW'(e.idc));
        check({tag, ":id_ex_rd1"},      id_ex_rd1,               e.rd1);
        check({tag, ":id_ex_rd2"},      id_ex_rd2,               e.rd2);
        check({tag, ":id_ex_imm"},      id_ex_imm,               e.imm);
        check({tag, ":id_ex_regs"},     DW'(id_ex_regs),         DW'(e.regs));
        check({tag, ":ex_mem_ctrl"},    DW'(ex_mem_ctrl),        DW'(e.exc));
        check({tag, ":ex_mem_dst"},     DW'(ex_mem_dst),         DW'(e.dst));
        check({tag, ":ex_mem_zero"},    DW'(ex_mem_zero),        DW'(e.zero));
        check({tag, ":ex_mem_alu"},     ex_mem_alu_result,       e.alu);
        check({tag, ":ex_mem_wdata"},   ex_mem_wdata,            e.wdata);
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.instr = NOP_INSTR; z.pc4 = '0; z.page = '0;
        z.idc = '0; z.rd1 = '0; z.rd2 = '0; z.imm = '0; z.regs = '0;
        z.exc = '0; z.dst = '0; z.zero = 1'b0; z.alu = '0; z.wdata = '0;
        return z;
    endfunction

    // Predict the next edge from current inputs, push it, clock, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        if (!rst) begin
            m = zero_exp();
        end else begin
            if (if_id_flush) begin
                m.instr = NOP_INSTR; m.pc4 = '0; m.page = '0;
            end else if (if_id_write) begin
                m.instr = if_instr; m.pc4 = if_pc_plus4; m.page = if_pc_page;
            end
            m.idc = id_ctrl; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.regs = id_regs;
            m.exc = ex_ctrl; m.dst = ex_dst; m.zero = ex_zero; m.alu = ex_alu_result; m.wdata = ex_wdata;
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare_all(tag, e);
    endtask

    initial begin
        id_ctrl_t c;
        exp_t     e;

        // Reset with all inputs driven nonzero
        rst = 1'b0; if_id_flush = 1'b0; if_id_write = 1'b1;
        if_instr = 32'hFFFF_FFFF; if_pc_plus4 = 32'h1234_5678; if_pc_page = 4'hF;
        id_ctrl = '1; id_rd1 = 32'hAAAA_AAAA; id_rd2 = 32'h5555_5555; id_imm = 32'h0F0F_0F0F;
        id_regs = '1; ex_ctrl = '1; ex_dst = '1; ex_zero = 1'b1;
        ex_alu_result = 32'hCAFE_F00D; ex_wdata = 32'h0BAD_BEEF;
        m = zero_exp();
        step("reset0");
        step("reset1");
        rst = 1'b1;
        #1;
        compare_all("release_pre_edge", zero_exp());

        // IF/ID load then stall
        if_instr = 32'h8C22_0004; if_pc_plus4 = 32'h0000_0008; if_pc_page = 4'h0;
        step("if_load");
        check("if_load_const", if_id_instr, 32'h8C22_0004);
        if_id_write = 1'b0; if_instr = 32'h1234_5678;
        step("if_stall0");
        step("if_stall1");
        check("if_stall_const", if_id_instr, 32'h8C22_0004);

        // Flush wins over stall; flush together with reset also clears
        if_id_flush = 1'b1;
        step("if_flush");
        check("if_flush_const", if_id_instr, 32'h0000_0000);
        if_id_flush = 1'b0; if_id_write = 1'b1; if_instr = 32'hAABB_CCDD; if_pc_page = 4'h9;
        step("if_reload");
        if_id_flush = 1'b1; rst = 1'b0;
        step("flush_with_reset");
        rst = 1'b1; if_id_flush = 1'b0;

        // ID/EX pass-through and bubble
        c.mem_write = 1'b0; c.mem_read = 1'b1; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        c.mem_to_reg = 1'b0; c.alu_src = 1'b1; c.alu_op = 3'b010;
        id_ctrl = c; id_rd1 = 32'd5; id_rd2 = 32'd7; id_imm = 32'hFFFF_FFFC;
        id_regs = {5'd1, 5'd2, 5'd3};
        step("id_ex_load");
        check("id_ex_ctrl_const", DW'(id_ex_ctrl), DW'(9'b011101010));
        check("id_ex_regs_const", DW'(id_ex_regs), DW'(15'b00001_00010_00011));
        id_ctrl = '0;
        step("id_ex_bubble");

        // EX/MEM pass-through then mid-stream reset pulse
        ex_ctrl = to_ex_ctrl(c); ex_dst = 5'd9; ex_zero = 1'b1;
        ex_alu_result = 32'h0000_0040; ex_wdata = 32'hDEAD_BEEF;
        step("ex_mem_load");
        check("ex_mem_ctrl_const", DW'(ex_mem_ctrl), DW'(4'b0110));
        ex_ctrl = 4'b0111;
        step("ex_mem_load2");
        rst = 1'b0;
        step("mid_reset");
        rst = 1'b1;

        // Random traffic including stalls and flushes
        for (int i = 0; i < 40; i++) begin
            if_id_write   = ($urandom_range(0, 3) != 0);
            if_id_flush   = ($urandom_range(0, 7) == 0);
            if_instr      = $urandom; if_pc_plus4 = $urandom;
            if_pc_page    = PAGE_W'($urandom);
            id_ctrl       = ID_CTRL_W'($urandom);
            id_rd1        = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_regs       = (3*RW)'($urandom);
            ex_ctrl       = EX_CTRL_W'($urandom);
            ex_dst        = RW'($urandom);
            ex_zero       = 1'($urandom);
            ex_alu_result = $urandom; ex_wdata = $urandom;
            step("random");
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end
        e = zero_exp();
        if (e.instr !== NOP_INSTR) $display("note: unexpected nop encoding");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
